// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch responder with a one-entry instruction buffer.
// Takes the current pc, returns the buffered word when it matches, and otherwise
// runs a req/ack read to a variable-latency instruction memory while holding stall.
// Optional feature macro: FETCH_TIMEOUT_EN (bounded wait for mem_ack, sticky bus_err).
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   pc         current program counter
//   inst       buffered instruction word (valid when inst_valid)
//   inst_valid buffer holds the word for pc this cycle
//   stall      ~inst_valid, freezes PC/pipeline
//   misalign   pc[1:0] != 0 (status only)
//   bus_err    sticky fetch-timeout flag (tied 0 without FETCH_TIMEOUT_EN)
//   mem_req    read request, high only while waiting for mem_ack
//   mem_addr   registered word address of the request
//   mem_ack    memory completes the read this cycle
//   mem_rdata  read data, sampled when mem_ack
module inst_fetch #(
  parameter int unsigned TD      = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  // Elaboration-time parameter sanity; TD is a simulation-only delay with no
  // effect on the synthesized logic.
  if (TIMEOUT < 1 || TIMEOUT > 255 || TD > 255) begin : g_bad_param
    $error("inst_fetch: parameter out of range");
  end

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            buf_valid;
  logic [AW-1:0]   buf_addr;
  logic [DW-1:0]   buf_data;
  logic [AW-1:0]   req_addr;
  logic            hit;
  logic            start_req;
  logic            fill_ack;

  // Combinational hit against the one-entry buffer
  assign hit        = buf_valid && (buf_addr == pc[31:2]);
  assign inst       = buf_data;
  assign inst_valid = hit;
  assign stall      = ~hit;
  assign misalign   = (pc[1:0] != 2'b00);
  assign mem_req    = (state == REQ);
  assign mem_addr   = req_addr;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       fill_to;
  logic       err_q;

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Next-state and transaction-control decode
  always_comb begin
    state_nxt = state;
    start_req = 1'b0;
    fill_ack  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    fill_to   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!hit) begin
          state_nxt = REQ;
          start_req = 1'b1;
        end
      end
      REQ: begin
        // ack on the timeout edge still wins
        if (mem_ack) begin
          fill_ack  = 1'b1;
          state_nxt = IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          fill_to   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, buffer and request-address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      req_addr  <= '0;
    end else begin
      state <= state_nxt;
      if (start_req) begin
        req_addr <= pc[31:2];
      end
      if (fill_ack) begin
        buf_valid <= 1'b1;
        buf_addr  <= req_addr;
        buf_data  <= mem_rdata;
      end
`ifdef FETCH_TIMEOUT_EN
      else if (fill_to) begin
        // Timed-out fetch returns a NOP so the core can make progress
        buf_valid <= 1'b1;
        buf_addr  <= req_addr;
        buf_data  <= '0;
      end
`endif
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start_req) begin
        wait_cnt <= '0;
      end else if (state == REQ && !mem_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (fill_to) begin
        err_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural fetch model.
module tb_inst_fetch;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  inst_fetch #(.TD(1), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .stall(stall), .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  // Memory responder: ack after a chosen number of wait cycles, random noise otherwise
  int          lat_cfg = 0;
  bit          never_ack = 1'b0;
  bit          in_txn = 1'b0;
  int          cnt = 0;
  logic [31:0] last_ack_data = 32'h0;

  always @(posedge clk) begin
    #1;
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        cnt = (lat_cfg < 0) ? int'($urandom_range(0, 5)) : lat_cfg;
      end
      if (!never_ack && cnt == 0) begin
        mem_ack = 1'b1;
        last_ack_data = mem_rdata;
      end else begin
        mem_ack = 1'b0;
        if (cnt > 0) cnt--;
      end
    end else begin
      in_txn = 1'b0;
      mem_ack = ($urandom_range(0, 3) == 0);
    end
  end

  // Behavioural model: one outstanding fetch, one buffered word
  bit          m_busy, m_bv, m_err;
  logic [29:0] m_req_addr, m_baddr;
  logic [31:0] m_bdata;
  int          m_waited;
  logic        exp_hit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_bv = 0; m_err = 0; m_req_addr = '0; m_baddr = '0; m_bdata = '0; m_waited = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_bv = 1; m_baddr = m_req_addr; m_bdata = mem_rdata; m_busy = 0;
      end
`ifdef FETCH_TIMEOUT_EN
      else if (m_waited + 1 >= int'(TB_TIMEOUT)) begin
        m_bv = 1; m_baddr = m_req_addr; m_bdata = 32'h0; m_err = 1; m_busy = 0;
      end
`endif
      else m_waited++;
    end else if (!(m_bv && m_baddr == pc[31:2])) begin
      m_busy = 1; m_req_addr = pc[31:2]; m_waited = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      exp_hit = m_bv && (m_baddr == pc[31:2]);
      check("inst_valid", 32'(inst_valid), 32'(exp_hit));
      check("stall", 32'(stall), 32'(!exp_hit));
      check("inst", inst, m_bdata);
      check("mem_req", 32'(mem_req), 32'(m_busy));
      if (m_busy) check("mem_addr", 32'(mem_addr), 32'(m_req_addr));
      check("misalign", 32'(misalign), 32'(pc[1:0] != 2'b00));
      check("bus_err", 32'(bus_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] d;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    check("rst_inst", inst, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);

    // Cold miss, zero-wait memory
    step(); rst = 1'b0; pc = 32'h0000_0040; lat_cfg = 0;
    @(negedge clk);
    check("cold_c0_stall", 32'(stall), 32'd1);
    check("cold_c0_req", 32'(mem_req), 32'd0);
    step(); @(negedge clk);
    check("cold_c1_req", 32'(mem_req), 32'd1);
    check("cold_c1_addr", 32'(mem_addr), 32'h10);
    d = last_ack_data;
    step(); @(negedge clk);
    check("cold_c2_valid", 32'(inst_valid), 32'd1);
    check("cold_c2_inst", inst, d);
    check("cold_c2_req", 32'(mem_req), 32'd0);
    step(); @(negedge clk);
    check("cold_c3_valid", 32'(inst_valid), 32'd1);
    check("cold_c3_req", 32'(mem_req), 32'd0);

    // Wait states: ack in the fourth request cycle
    step(); pc = 32'h0000_0080; lat_cfg = 3;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) check("ws_stall", 32'(stall), 32'd1);
      else begin
        check("ws_valid", 32'(inst_valid), 32'd1);
        check("ws_inst", inst, last_ack_data);
      end
      if (c >= 1 && c <= 4) check("ws_addr", 32'(mem_addr), 32'h20);
      step();
    end

    // pc change while a request is outstanding
    pc = 32'h0000_0100; lat_cfg = 2;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        check("chg_req1", 32'(mem_req), 32'd1);
        check("chg_addr1", 32'(mem_addr), 32'h40);
      end
      if (c == 4) check("chg_gap", 32'(mem_req), 32'd0);
      if (c == 5) check("chg_addr2", 32'(mem_addr), 32'h80);
      check("chg_valid", 32'(inst_valid), (c == 6) ? 32'd1 : 32'd0);
      step();
      if (c == 1) begin pc = 32'h0000_0200; lat_cfg = 0; end
    end

    // Misaligned pc
    pc = 32'h0000_0042;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      check("mis_flag", 32'(misalign), 32'd1);
      if (c == 1) check("mis_addr", 32'(mem_addr), 32'h10);
      check("mis_valid", 32'(inst_valid), (c == 2) ? 32'd1 : 32'd0);
      step();
    end

    // Asynchronous reset in the middle of a request
    never_ack = 1'b1; pc = 32'h0000_0500;
    @(negedge clk);
    step(); @(negedge clk);
    check("rr_req_before", 32'(mem_req), 32'd1);
    step(); rst = 1'b1;
    #1;
    check("rr_req", 32'(mem_req), 32'd0);
    check("rr_valid", 32'(inst_valid), 32'd0);
    check("rr_err", 32'(bus_err), 32'd0);
    check("rr_inst", inst, 32'h0);
    check("rr_stall", 32'(stall), 32'd1);

    // Memory never answers
    step(); rst = 1'b0; pc = 32'h0000_0600;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) check("to_req", 32'(mem_req), 32'd1);
`ifdef FETCH_TIMEOUT_EN
      if (c >= 5) begin
        check("to_req_drop", 32'(mem_req), 32'd0);
        check("to_err", 32'(bus_err), 32'd1);
        check("to_inst", inst, 32'h0);
        check("to_valid", 32'(inst_valid), 32'd1);
      end
`else
      if (c >= 5) begin
        check("nto_req", 32'(mem_req), 32'd1);
        check("nto_err", 32'(bus_err), 32'd0);
        check("nto_valid", 32'(inst_valid), 32'd0);
      end
`endif
      step();
    end

    // Randomized traffic with a small address working set
    never_ack = 1'b0; lat_cfg = -1;
    for (int i = 0; i < 2000; i++) begin
      int unsigned w;
      int unsigned off;
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom_range(0, 7);
        off = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        pc = ($urandom_range(0, 15) == 0) ? $urandom : 32'h1000_0000 + 32'(w * 4 + off);
      end
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
